counter_checker: RTL and testbench

- Passive monitor on the far side of the mode counter interface. The stimulus side drives clk, enb, modo and D, and the counter returns Q and rco; this block reads all of those signals.
- Each cycle it predicts the counter's next Q/rco from the previous cycle's inputs, compares against the actual values, and reports mismatches with counts and first-failure capture.
- Instantiated once per counter: N=4 for the single counter, N=16 for the cascaded counter (rco taken from the top stage).

---
 rtl/counter_checker_pkg.sv | 20 ++
 rtl/counter_ref_model.sv | 54 +++++
 rtl/counter_checker.sv | 159 +++++++++++++++
 tb/tb_counter_checker.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_checker_pkg.sv
// Shared definitions for the mode-counter checker and its reference model.
// Holds the counter mode encodings, the down-by-three step size and the
// checker state encoding.
package counter_checker_pkg;

  localparam logic [1:0] MODE_UP    = 2'b00;
  localparam logic [1:0] MODE_DOWN  = 2'b01;
  localparam logic [1:0] MODE_DOWN3 = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam int unsigned DOWN3_STEP = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK  = 2'b01,
    CHECK = 2'b10,
    HALT  = 2'b11
  } state_e;

endpackage

// File: rtl/counter_ref_model.sv
// Combinational golden model of the mode counter: predicts the next Q and
// rco from the current Q and the enb/modo/D values applied to the counter.
// Ports:
//   q_prev  : counter value before the edge
//   enb     : counter enable
//   modo    : counter mode (up / down / down-by-3 / load)
//   D       : parallel-load data
//   q_exp   : predicted counter value after the edge
//   rco_exp : predicted ripple-carry / borrow output after the edge
module counter_ref_model
  import counter_checker_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] q_prev,
  input  logic         enb,
  input  logic [1:0]   modo,
  input  logic [N-1:0] D,
  output logic [N-1:0] q_exp,
  output logic         rco_exp
);

  localparam int unsigned W = N + 1;

  // Arithmetic in N+1 bits so the top bit is the carry/borrow.
  logic [W-1:0] ext;

  always_comb begin
    ext     = {1'b0, q_prev};
    rco_exp = 1'b0;
    if (enb) begin
      unique case (modo)
        MODE_UP: begin
          ext     = {1'b0, q_prev} + W'(1);
          rco_exp = ext[N];
        end
        MODE_DOWN: begin
          ext     = {1'b0, q_prev} - W'(1);
          rco_exp = ext[N];
        end
        MODE_DOWN3: begin
          ext     = {1'b0, q_prev} - W'(DOWN3_STEP);
          rco_exp = ext[N];
        end
        MODE_LOAD: begin
          ext     = {1'b0, D};
          rco_exp = 1'b0;
        end
      endcase
    end
    q_exp = ext[N-1:0];
  end

endmodule

// File: rtl/counter_checker.sv
// Passive checker for the mode counter. Each edge it compares the observed
// Q/rco against a prediction built from the previous edge's sample, counts
// matches and mismatches, and captures the first failing Q.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   enb, modo, D          : counter inputs as driven to the counter
//   Q, rco                : counter outputs under check
//   locked                : a valid prior sample exists and checking is live
//   err                   : one-cycle pulse after each mismatching edge
//   err_count/match_count : saturating mismatch / match counters
//   first_err_q/_exp      : observed / expected Q at the first mismatch
//   halted                : frozen after a mismatch when STOP_ON_ERR=1
module counter_checker
  import counter_checker_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned CW          = 16,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enb,
  input  logic [1:0]    modo,
  input  logic [N-1:0]  D,
  input  logic [N-1:0]  Q,
  input  logic          rco,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] match_count,
  output logic [N-1:0]  first_err_q,
  output logic [N-1:0]  first_err_exp,
  output logic          halted
);

  state_e         state, state_n;
  logic           locked_n, err_n, halted_n;
  logic [CW-1:0]  err_count_n, match_count_n;
  logic [N-1:0]   first_err_q_n, first_err_exp_n;

  // Previous-edge sample the prediction is built from.
  logic [N-1:0]   q_s, q_s_n, d_s, d_s_n;
  logic           enb_s, enb_s_n;
  logic [1:0]     modo_s, modo_s_n;

  logic [N-1:0]   q_exp;
  logic           rco_exp;
  logic           mismatch;
  logic           q_unknown;
  logic           capture;

  counter_ref_model #(.N(N)) u_ref (
    .q_prev  (q_s),
    .enb     (enb_s),
    .modo    (modo_s),
    .D       (d_s),
    .q_exp   (q_exp),
    .rco_exp (rco_exp)
  );

  // Q and rco faults on the same edge are a single mismatch.
  assign mismatch  = (Q != q_exp) || (rco != rco_exp);
  // Only meaningful in simulation; a real netlist never sees X/Z here.
  assign q_unknown = $isunknown(Q);

  // Next-state and next-output logic.
  always_comb begin
    state_n         = state;
    locked_n        = locked;
    err_n           = 1'b0;
    halted_n        = halted;
    err_count_n     = err_count;
    match_count_n   = match_count;
    first_err_q_n   = first_err_q;
    first_err_exp_n = first_err_exp;
    q_s_n           = q_s;
    enb_s_n         = enb_s;
    modo_s_n        = modo_s;
    d_s_n           = d_s;
    capture         = 1'b0;

    unique case (state)
      IDLE: begin
        capture = 1'b1;
        if (!q_unknown) state_n = LOCK;
      end
      LOCK: begin
        capture = 1'b1;
        if (q_unknown) begin
          state_n = IDLE;
        end else begin
          state_n  = CHECK;
          locked_n = 1'b1;
        end
      end
      CHECK: begin
        capture = 1'b1;
        if (mismatch) begin
          err_n = 1'b1;
          if (err_count != '1) err_count_n = err_count + CW'(1);
          if (err_count == '0) begin
            first_err_q_n   = Q;
            first_err_exp_n = q_exp;
          end
          if (STOP_ON_ERR) begin
            state_n  = HALT;
            locked_n = 1'b0;
            halted_n = 1'b1;
            capture  = 1'b0;
          end
        end else if (match_count != '1) begin
          match_count_n = match_count + CW'(1);
        end
      end
      HALT: begin
      end
    endcase

    // Re-capturing the observed Q resyncs the model after a fault.
    if (capture) begin
      q_s_n    = Q;
      enb_s_n  = enb;
      modo_s_n = modo;
      d_s_n    = D;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      locked        <= 1'b0;
      err           <= 1'b0;
      halted        <= 1'b0;
      err_count     <= '0;
      match_count   <= '0;
      first_err_q   <= '0;
      first_err_exp <= '0;
      q_s           <= '0;
      enb_s         <= 1'b0;
      modo_s        <= 2'b00;
      d_s           <= '0;
    end else begin
      state         <= state_n;
      locked        <= locked_n;
      err           <= err_n;
      halted        <= halted_n;
      err_count     <= err_count_n;
      match_count   <= match_count_n;
      first_err_q   <= first_err_q_n;
      first_err_exp <= first_err_exp_n;
      q_s           <= q_s_n;
      enb_s         <= enb_s_n;
      modo_s        <= modo_s_n;
      d_s           <= d_s_n;
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench for counter_checker: directed Q/rco vectors are applied,
// the expected checker response for each edge is queued, and a monitor
// compares queued expectations against the checker outputs.
module tb_counter_checker;

  localparam int unsigned CW = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic [1:0]  modo;

  logic [3:0]  d4, q4;
  logic        r4;
  logic        locked4, err4, halted4;
  logic [15:0] errc4, matc4;
  logic [3:0]  fq4, fe4;

  logic [15:0] d16, q16;
  logic        r16;
  logic        locked16, err16, halted16;
  logic [15:0] errc16, matc16;
  logic [15:0] fq16, fe16;

  always #5 clk = ~clk;

  counter_checker #(.N(4), .CW(CW), .STOP_ON_ERR(1'b0)) dut4 (
    .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(d4), .Q(q4), .rco(r4),
    .locked(locked4), .err(err4), .err_count(errc4), .match_count(matc4),
    .first_err_q(fq4), .first_err_exp(fe4), .halted(halted4)
  );

  counter_checker #(.N(16), .CW(CW), .STOP_ON_ERR(1'b1)) dut16 (
    .clk(clk), .reset(reset), .enb(enb), .modo(modo), .D(d16), .Q(q16), .rco(r16),
    .locked(locked16), .err(err16), .err_count(errc16), .match_count(matc16),
    .first_err_q(fq16), .first_err_exp(fe16), .halted(halted16)
  );

  typedef struct {
    bit          sel;
    logic        err;
    logic        locked;
    logic        halted;
    logic [15:0] errc;
    logic [15:0] matc;
    logic [15:0] fq;
    logic [15:0] fe;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Expected checker state, advanced by hand-marked match/mismatch edges.
  int          e_edges;
  logic        e_locked, e_halt;
  logic [15:0] e_errc, e_matc, e_fq, e_fe;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic clear_model();
    e_edges  = 0;
    e_locked = 1'b0;
    e_halt   = 1'b0;
    e_errc   = '0;
    e_matc   = '0;
    e_fq     = '0;
    e_fe     = '0;
  endtask

  // Apply one edge of stimulus; q/r are what the counter presents at this
  // edge, mis marks a hand-determined mismatch with qx the expected Q.
  task automatic step(input bit sel, input logic en, input logic [1:0] m,
                      input logic [15:0] d, input logic [15:0] q, input logic r,
                      input bit mis, input logic [15:0] qx);
    exp_t e;
    enb  = en;
    modo = m;
    if (sel) begin
      d16 = d; q16 = q; r16 = r;
    end else begin
      d4 = d[3:0]; q4 = q[3:0]; r4 = r;
    end
    @(posedge clk);
    #1;
    e_edges++;
    e.err = 1'b0;
    if (!e_halt) begin
      if (e_edges == 2) begin
        e_locked = 1'b1;
      end else if (e_edges >= 3) begin
        if (mis) begin
          e.err = 1'b1;
          if (e_errc == 16'h0) begin
            e_fq = q;
            e_fe = qx;
          end
          e_errc = e_errc + 16'h1;
          if (sel) begin
            e_halt   = 1'b1;
            e_locked = 1'b0;
          end
        end else begin
          e_matc = e_matc + 16'h1;
        end
      end
    end
    e.sel    = sel;
    e.locked = e_locked;
    e.halted = e_halt;
    e.errc   = e_errc;
    e.matc   = e_matc;
    e.fq     = e_fq;
    e.fe     = e_fe;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Pulse reset between edges; called just after a falling edge.
  task automatic pulse_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    clear_model();
  endtask

  // Monitor: compare queued expectations at each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.sel) begin
          check("n4_err",    16'(err4),    16'(e.err));
          check("n4_locked", 16'(locked4), 16'(e.locked));
          check("n4_halted", 16'(halted4), 16'(e.halted));
          check("n4_errc",   errc4,        e.errc);
          check("n4_matc",   matc4,        e.matc);
          check("n4_fq",     16'(fq4),     e.fq);
          check("n4_fe",     16'(fe4),     e.fe);
        end else begin
          check("n16_err",    16'(err16),    16'(e.err));
          check("n16_locked", 16'(locked16), 16'(e.locked));
          check("n16_halted", 16'(halted16), 16'(e.halted));
          check("n16_errc",   errc16,        e.errc);
          check("n16_matc",   matc16,        e.matc);
          check("n16_fq",     fq16,          e.fq);
          check("n16_fe",     fe16,          e.fe);
        end
      end
    end
  end

  logic [3:0] dn3_q   [8] = '{4'hF, 4'hC, 4'h9, 4'h6, 4'h3, 4'h0, 4'hD, 4'hA};
  logic       dn3_rco [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] dn1_q   [6] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA};

  initial begin
    reset = 1'b1;
    enb = 1'b0; modo = 2'b00;
    d4 = '0; q4 = '0; r4 = 1'b0;
    d16 = '0; q16 = '0; r16 = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    check("reset_locked", 16'(locked4), 16'h0);
    check("reset_errc",   errc4,        16'h0);
    check("reset_matc",   matc4,        16'h0);
    reset = 1'b0;

    // Load 0 twice, then count up through the wrap with rco on F->0.
    step(0, 1, 2'b11, 16'h0, 16'h0, 0, 0, 0);
    step(0, 1, 2'b11, 16'h0, 16'h0, 0, 0, 0);
    step(0, 1, 2'b00, 16'h0, 16'h0, 0, 0, 0);
    for (int i = 1; i < 16; i++) step(0, 1, 2'b00, 16'h0, 16'(i), 0, 0, 0);
    step(0, 1, 2'b00, 16'h0, 16'h0, 1, 0, 0);
    step(0, 1, 2'b11, 16'hF, 16'h1, 0, 0, 0);

    // Down-by-3 from F, borrow when 0 -> D; last edge reloads F.
    for (int i = 0; i < 8; i++)
      step(0, 1, (i == 7) ? 2'b11 : 2'b10, 16'hF, 16'(dn3_q[i]), dn3_rco[i], 0, 0);

    // Down-by-1 from F, with 7 presented where 9 is due, then resync.
    for (int i = 0; i < 6; i++) step(0, 1, 2'b01, 16'hF, 16'(dn1_q[i]), 0, 0, 0);
    step(0, 1, 2'b01, 16'hF, 16'h7, 0, 1, 16'h9);
    step(0, 1, 2'b01, 16'hF, 16'h6, 0, 0, 0);

    // Hold with enb=0 at 5; Q fault then rco-only fault.
    step(0, 0, 2'b01, 16'hF, 16'h5, 0, 0, 0);
    step(0, 0, 2'b01, 16'hF, 16'h5, 0, 0, 0);
    step(0, 0, 2'b01, 16'hF, 16'h6, 0, 1, 16'h5);
    step(0, 1, 2'b01, 16'hF, 16'h6, 1, 1, 16'h6);
    step(0, 1, 2'b01, 16'hF, 16'h5, 0, 0, 0);

    // Asynchronous reset between edges while checking.
    #2 reset = 1'b1;
    #1;
    check("async_locked", 16'(locked4), 16'h0);
    check("async_err",    16'(err4),    16'h0);
    check("async_errc",   errc4,        16'h0);
    check("async_matc",   matc4,        16'h0);
    check("async_fq",     16'(fq4),     16'h0);
    check("async_fe",     16'(fe4),     16'h0);
    check("async_halted", 16'(halted4), 16'h0);
    #1 reset = 1'b0;
    clear_model();
    step(0, 1, 2'b00, 16'h0, 16'h3, 0, 0, 0);
    step(0, 1, 2'b00, 16'h0, 16'h4, 0, 0, 0);
    step(0, 1, 2'b00, 16'h0, 16'h5, 0, 0, 0);
    step(0, 1, 2'b00, 16'h0, 16'h7, 0, 1, 16'h6);
    step(0, 1, 2'b00, 16'h0, 16'h8, 0, 0, 0);

    // 16-bit checker that halts on the first mismatch.
    pulse_reset();
    step(1, 1, 2'b11, 16'hFFFE, 16'h0000, 0, 0, 0);
    step(1, 1, 2'b00, 16'hFFFE, 16'hFFFE, 0, 0, 0);
    step(1, 1, 2'b00, 16'h0000, 16'hFFFF, 0, 0, 0);
    step(1, 1, 2'b00, 16'h0000, 16'h0000, 1, 0, 0);
    step(1, 1, 2'b00, 16'h0000, 16'h1234, 0, 1, 16'h0001);
    for (int i = 0; i < 10; i++)
      step(1, 1, 2'(i), 16'h5A5A + 16'(i), 16'(i * 7), i[0], 0, 0);

    repeat (2) @(negedge clk);
    check("sb_drained", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
